// File: rtl/demultiplexor_tdm_1a4.sv
// Receive side of a 4-slot TDM link: hunts for the slot-0 sync marker, stages slots 0..2,
// and publishes a full frame on A..D when slot 3 arrives. Framing errors are flagged.
module demultiplexor_tdm_1a4 #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] Entrada,
    input  logic             Valido,
    input  logic             Sincronia,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] D,
    output logic [1:0]       Selector,
    output logic             Trama_valida,
    output logic             Error_sync
);

    localparam int unsigned SEL_W = 2;

    typedef enum logic {
        BUSCAR  = 1'b0,
        RECIBIR = 1'b1
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [SEL_W-1:0]   r_sel, w_sel_nxt;
    logic [WIDTH-1:0]   r_stg0, r_stg1, r_stg2;
    logic [WIDTH-1:0]   w_stg0_nxt, w_stg1_nxt, w_stg2_nxt;
    logic [WIDTH-1:0]   r_a, r_b, r_c, r_d;
    logic [WIDTH-1:0]   w_a_nxt, w_b_nxt, w_c_nxt, w_d_nxt;
    logic               r_trama, w_trama_nxt;
    logic               r_err, w_err_nxt;

    // State, staging and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= BUSCAR;
            r_sel   <= '0;
            r_stg0  <= '0;
            r_stg1  <= '0;
            r_stg2  <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_d     <= '0;
            r_trama <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_stg0  <= w_stg0_nxt;
            r_stg1  <= w_stg1_nxt;
            r_stg2  <= w_stg2_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_c     <= w_c_nxt;
            r_d     <= w_d_nxt;
            r_trama <= w_trama_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Next-state and next-output logic; invalid cycles hold everything and drop pulses
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_stg0_nxt  = r_stg0;
        w_stg1_nxt  = r_stg1;
        w_stg2_nxt  = r_stg2;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_c_nxt     = r_c;
        w_d_nxt     = r_d;
        w_trama_nxt = 1'b0;
        w_err_nxt   = 1'b0;

        if (Valido) begin
            case (r_state)
                BUSCAR: begin
                    if (Sincronia) begin
                        w_stg0_nxt  = Entrada;
                        w_sel_nxt   = SEL_W'(1);
                        w_state_nxt = RECIBIR;
                    end
                end
                RECIBIR: begin
                    if (Sincronia) begin
                        // A sync mid-frame aborts the partial frame but still starts a new one
                        w_err_nxt  = (r_sel != '0);
                        w_stg0_nxt = Entrada;
                        w_sel_nxt  = SEL_W'(1);
                    end else begin
                        case (r_sel)
                            2'd0: begin
                                w_err_nxt   = 1'b1;
                                w_sel_nxt   = '0;
                                w_state_nxt = BUSCAR;
                            end
                            2'd1: begin
                                w_stg1_nxt = Entrada;
                                w_sel_nxt  = r_sel + SEL_W'(1);
                            end
                            2'd2: begin
                                w_stg2_nxt = Entrada;
                                w_sel_nxt  = r_sel + SEL_W'(1);
                            end
                            default: begin
                                w_a_nxt     = r_stg0;
                                w_b_nxt     = r_stg1;
                                w_c_nxt     = r_stg2;
                                w_d_nxt     = Entrada;
                                w_trama_nxt = 1'b1;
                                w_sel_nxt   = '0;
                            end
                        endcase
                    end
                end
                default: begin
                    w_state_nxt = BUSCAR;
                    w_sel_nxt   = '0;
                end
            endcase
        end
    end

    assign A            = r_a;
    assign B            = r_b;
    assign C            = r_c;
    assign D            = r_d;
    assign Selector     = r_sel;
    assign Trama_valida = r_trama;
    assign Error_sync   = r_err;

endmodule

// File: tb/tb_demultiplexor_tdm_1a4.sv
// Directed self-checking bench for demultiplexor_tdm_1a4 with hand-computed expectations.
module tb_demultiplexor_tdm_1a4;

    localparam int unsigned WIDTH = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] Entrada;
    logic             Valido;
    logic             Sincronia;
    logic [WIDTH-1:0] A, B, C, D;
    logic [1:0]       Selector;
    logic             Trama_valida;
    logic             Error_sync;

    int n_checks = 0;
    int n_pass   = 0;

    demultiplexor_tdm_1a4 #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Entrada      (Entrada),
        .Valido       (Valido),
        .Sincronia    (Sincronia),
        .A            (A),
        .B            (B),
        .C            (C),
        .D            (D),
        .Selector     (Selector),
        .Trama_valida (Trama_valida),
        .Error_sync   (Error_sync)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one cycle, then sample 1ns after the rising edge
    task automatic step(input logic v, input logic s, input logic [WIDTH-1:0] d);
        Valido    = v;
        Sincronia = s;
        Entrada   = d;
        @(posedge clk);
        #1;
        check("pulse_excl", 32'(Trama_valida & Error_sync), 32'd0);
    endtask

    task automatic chk_st(input string tag, input logic [1:0] sel, input logic tv, input logic er);
        check({tag, "_sel"}, 32'(Selector), 32'(sel));
        check({tag, "_tv"},  32'(Trama_valida), 32'(tv));
        check({tag, "_err"}, 32'(Error_sync), 32'(er));
    endtask

    task automatic chk_out(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
        check({tag, "_A"}, 32'(A), 32'(a));
        check({tag, "_B"}, 32'(B), 32'(b));
        check({tag, "_C"}, 32'(C), 32'(c));
        check({tag, "_D"}, 32'(D), 32'(d));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b0, 1'b0, '0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        Valido    = 1'b0;
        Sincronia = 1'b0;
        Entrada   = '0;

        // 1: reset state, then back-to-back frame
        do_reset();
        chk_out("t1_rst", 3'b000, 3'b000, 3'b000, 3'b000);
        chk_st("t1_rst", 2'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 3'b001); chk_st("t1_w0", 2'd1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 3'b100); chk_st("t1_w1", 2'd2, 1'b0, 1'b0);
        step(1'b1, 1'b0, 3'b101); chk_st("t1_w2", 2'd3, 1'b0, 1'b0);
        chk_out("t1_hold", 3'b000, 3'b000, 3'b000, 3'b000);
        step(1'b1, 1'b0, 3'b110); chk_st("t1_w3", 2'd0, 1'b1, 1'b0);
        chk_out("t1_frame", 3'b001, 3'b100, 3'b101, 3'b110);
        step(1'b0, 1'b0, 3'b000); chk_st("t1_idle", 2'd0, 1'b0, 1'b0);

        // 2: same frame with invalid gaps (gap cycles carry junk incl. sync)
        do_reset();
        step(1'b1, 1'b1, 3'b001); chk_st("t2_w0", 2'd1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'b111); chk_st("t2_g0", 2'd1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 3'b100); chk_st("t2_w1", 2'd2, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'b011); chk_st("t2_g1a", 2'd2, 1'b0, 1'b0);
        step(1'b0, 1'b0, 3'b010); chk_st("t2_g1b", 2'd2, 1'b0, 1'b0);
        step(1'b1, 1'b0, 3'b101); chk_st("t2_w2", 2'd3, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'b000); chk_st("t2_g2a", 2'd3, 1'b0, 1'b0);
        step(1'b0, 1'b0, 3'b111); chk_st("t2_g2b", 2'd3, 1'b0, 1'b0);
        step(1'b0, 1'b0, 3'b111); chk_st("t2_g2c", 2'd3, 1'b0, 1'b0);
        chk_out("t2_hold", 3'b000, 3'b000, 3'b000, 3'b000);
        step(1'b1, 1'b0, 3'b110); chk_st("t2_w3", 2'd0, 1'b1, 1'b0);
        chk_out("t2_frame", 3'b001, 3'b100, 3'b101, 3'b110);

        // 3: sync arriving at slot 2 restarts the frame with an error pulse
        step(1'b1, 1'b1, 3'b111); chk_st("t3_s0", 2'd1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 3'b010); chk_st("t3_s1", 2'd2, 1'b0, 1'b0);
        step(1'b1, 1'b1, 3'b011); chk_st("t3_resync", 2'd1, 1'b0, 1'b1);
        chk_out("t3_hold", 3'b001, 3'b100, 3'b101, 3'b110);
        step(1'b1, 1'b0, 3'b000); chk_st("t3_w1", 2'd2, 1'b0, 1'b0);
        step(1'b1, 1'b0, 3'b001); chk_st("t3_w2", 2'd3, 1'b0, 1'b0);
        chk_out("t3_hold2", 3'b001, 3'b100, 3'b101, 3'b110);
        step(1'b1, 1'b0, 3'b010); chk_st("t3_w3", 2'd0, 1'b1, 1'b0);
        chk_out("t3_frame", 3'b011, 3'b000, 3'b001, 3'b010);

        // 4: missing sync at slot 0 -> error, then hunting ignores non-sync words
        step(1'b1, 1'b0, 3'b101); chk_st("t4_nosync", 2'd0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 3'b111); chk_st("t4_ign0", 2'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 3'b010); chk_st("t4_ign1", 2'd0, 1'b0, 1'b0);
        chk_out("t4_hold", 3'b011, 3'b000, 3'b001, 3'b010);

        // 5: junk after reset, then a clean frame
        do_reset();
        step(1'b1, 1'b0, 3'b111); chk_st("t5_j0", 2'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 3'b111); chk_st("t5_j1", 2'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 3'b010); chk_st("t5_w0", 2'd1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 3'b011);
        step(1'b1, 1'b0, 3'b100);
        step(1'b1, 1'b0, 3'b101); chk_st("t5_w3", 2'd0, 1'b1, 1'b0);
        chk_out("t5_frame", 3'b010, 3'b011, 3'b100, 3'b101);

        // 6: reset mid-frame discards the partial frame
        step(1'b1, 1'b1, 3'b110);
        step(1'b1, 1'b0, 3'b001); chk_st("t6_pre", 2'd2, 1'b0, 1'b0);
        do_reset();
        chk_out("t6_rst", 3'b000, 3'b000, 3'b000, 3'b000);
        chk_st("t6_rst", 2'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 3'b011); chk_st("t6_hunt", 2'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 3'b100); chk_st("t6_w0", 2'd1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 3'b001);
        step(1'b1, 1'b0, 3'b010);
        step(1'b1, 1'b0, 3'b111); chk_st("t6_w3", 2'd0, 1'b1, 1'b0);
        chk_out("t6_frame", 3'b100, 3'b001, 3'b010, 3'b111);
        step(1'b0, 1'b0, 3'b000); chk_st("t6_idle", 2'd0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
